// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues word reads to instruction memory, buffers the
// returned words with their addresses in a prefetch FIFO, and hands them to decode.
module inst_fetch_unit #(
  parameter int                ADDR_W     = 30,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_req,
  input  logic [DATA_W-1:0] inst_bus,
  output logic [DATA_W-1:0] ib,
  output logic [ADDR_W-1:0] ib_pc,
  output logic              ib_valid,
  input  logic              ib_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic {HOLD, FETCH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              inst_req_q, inst_req_d;
  logic              inflight_q, inflight_d;
  logic              stale_q, stale_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              push, pop, issue, mem_we;
  logic [OCC_W-1:0]  occupancy;

  // Occupancy counts buffered words plus both pipeline slots that may still deliver one,
  // so the FIFO can never be asked to accept more than DEPTH words.
  assign occupancy = OCC_W'(count_q) + OCC_W'(inst_req_q) + OCC_W'(inflight_q);

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    inst_addr_d = inst_addr_q;
    inst_req_d  = 1'b0;
    inflight_d  = inst_req_q;
    stale_d     = 1'b0;
    resp_addr_d = inst_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    push   = inflight_q && !stale_q;
    pop    = (count_q != '0) && ib_ready;
    issue  = ((state_q == FETCH) || go) && (occupancy < OCC_W'(DEPTH));
    mem_we = 1'b0;

    if (state_q == HOLD && go) state_d = FETCH;

    if (redirect) begin
      // Flush wins over everything; a request on the bus now returns next cycle and is dropped.
      pc_d     = redirect_addr;
      stale_d  = inst_req_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        inst_req_d  = 1'b1;
        inst_addr_d = pc_q;
        pc_d        = pc_q + ADDR_W'(1);
      end
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= HOLD;
      pc_q        <= RESET_ADDR;
      inst_addr_q <= RESET_ADDR;
      inst_req_q  <= 1'b0;
      inflight_q  <= 1'b0;
      stale_q     <= 1'b0;
      resp_addr_q <= RESET_ADDR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_addr_q <= inst_addr_d;
      inst_req_q  <= inst_req_d;
      inflight_q  <= inflight_d;
      stale_q     <= stale_d;
      resp_addr_q <= resp_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q gates visibility, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      data_mem[wr_ptr_q] <= inst_bus;
      pc_mem[wr_ptr_q]   <= resp_addr_q;
    end
  end

  assign inst_addr = inst_addr_q;
  assign inst_req  = inst_req_q;
  assign ib        = data_mem[rd_ptr_q];
  assign ib_pc     = pc_mem[rd_ptr_q];
  assign ib_valid  = (count_q != '0);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; memory returns its word address tagged with 2'b01
// in the top bits so data and address mix-ups are visible.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, go, inst_req, ib_valid, ib_ready, redirect;
  logic [29:0] inst_addr, ib_pc, redirect_addr;
  logic [31:0] inst_bus, ib;

  int errors = 0;
  int checks = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .go(go),
    .inst_addr(inst_addr), .inst_req(inst_req), .inst_bus(inst_bus),
    .ib(ib), .ib_pc(ib_pc), .ib_valid(ib_valid), .ib_ready(ib_ready),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  // Memory responds one cycle after a request.
  always @(posedge clk) inst_bus <= inst_req ? {2'b01, inst_addr} : 32'hDEAD_BEEF;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return {2'b01, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [29:0] pc);
    check({tag, ".valid"}, 64'(ib_valid), 64'(1));
    check({tag, ".pc"},    64'(ib_pc),    64'(pc));
    check({tag, ".ib"},    64'(ib),       64'(word_of(pc)));
  endtask

  logic [29:0] wrap_seq [4];

  initial begin
    wrap_seq[0] = 30'h3FFF_FFFE; wrap_seq[1] = 30'h3FFF_FFFF;
    wrap_seq[2] = 30'h0;         wrap_seq[3] = 30'h1;
    rst = 1'b1; go = 1'b0; ib_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    step(); step();
    check("reset.valid", 64'(ib_valid),  64'(0));
    check("reset.req",   64'(inst_req),  64'(0));
    check("reset.addr",  64'(inst_addr), 64'(0));

    // Cold start with decode always ready.
    rst = 1'b0; go = 1'b1; ib_ready = 1'b1;
    step(); go = 1'b0;
    check("cold.c1.req",   64'(inst_req),  64'(1));
    check("cold.c1.addr",  64'(inst_addr), 64'(0));
    check("cold.c1.valid", 64'(ib_valid),  64'(0));
    step();
    check("cold.c2.addr",  64'(inst_addr), 64'(1));
    check("cold.c2.valid", 64'(ib_valid),  64'(0));
    for (int i = 0; i < 6; i++) begin
      step();
      check_head($sformatf("cold.head%0d", i), 30'(i));
      check($sformatf("cold.addr%0d", i), 64'(inst_addr), 64'(i + 2));
    end

    // Backpressure: four requests fill the FIFO, then fetch stalls.
    rst = 1'b1; step(); rst = 1'b0; go = 1'b1; ib_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(); go = 1'b0;
      check($sformatf("bp.c%0d.req", k), 64'(inst_req), 64'(k <= 4));
      if (k <= 4) check($sformatf("bp.c%0d.addr", k), 64'(inst_addr), 64'(k - 1));
    end
    check("bp.count", 64'(dut.count_q), 64'(4));
    check_head("bp.head0", 30'h0);
    ib_ready = 1'b1;
    step(); check_head("bp.head1", 30'h1);
    step(); check_head("bp.head2", 30'h2);
    check("bp.resume.req",  64'(inst_req),  64'(1));
    check("bp.resume.addr", 64'(inst_addr), 64'(4));
    step(); check_head("bp.head3", 30'h3);
    check("bp.req5", 64'(inst_addr), 64'(5));

    // Redirect while word 5 is requested, word 4 returning and head 3 being popped.
    redirect = 1'b1; redirect_addr = 30'h100;
    step(); redirect = 1'b0;
    check("rd.c1.valid", 64'(ib_valid), 64'(0));
    check("rd.c1.req",   64'(inst_req), 64'(0));
    step();
    check("rd.c2.valid", 64'(ib_valid),  64'(0));
    check("rd.c2.req",   64'(inst_req),  64'(1));
    check("rd.c2.addr",  64'(inst_addr), 64'(30'h100));
    step();
    check("rd.c3.valid", 64'(ib_valid),  64'(0));
    check("rd.c3.addr",  64'(inst_addr), 64'(30'h101));
    step(); check_head("rd.head100", 30'h100);
    step(); check_head("rd.head101", 30'h101);

    // Redirect near the top of the address space.
    redirect = 1'b1; redirect_addr = 30'h3FFF_FFFE;
    step(); redirect = 1'b0;
    check("wrap.req0", 64'(inst_req), 64'(0));
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 4) check($sformatf("wrap.addr%0d", k), 64'(inst_addr), 64'(wrap_seq[k]));
      if (k >= 2) check_head($sformatf("wrap.head%0d", k - 2), wrap_seq[k - 2]);
    end

    // Stall decode to build 3 entries with 1 in flight, then reset.
    ib_ready = 1'b0;
    step();
    check_head("rst.hold1", 30'h1);
    check("rst.addr4", 64'(inst_addr), 64'(4));
    step();
    check("rst.count3",  64'(dut.count_q),  64'(3));
    check("rst.noreq",   64'(inst_req),     64'(0));
    rst = 1'b1;
    step(); rst = 1'b0;
    check("rst.valid", 64'(ib_valid),  64'(0));
    check("rst.req",   64'(inst_req),  64'(0));
    check("rst.addr",  64'(inst_addr), 64'(0));
    ib_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("hold.valid%0d", k), 64'(ib_valid), 64'(0));
      check($sformatf("hold.req%0d", k),   64'(inst_req), 64'(0));
    end
    go = 1'b1;
    step(); go = 1'b0;
    check("restart.req",  64'(inst_req),  64'(1));
    check("restart.addr", 64'(inst_addr), 64'(0));
    step(); step();
    check_head("restart.head0", 30'h0);
    step();
    check_head("restart.head1", 30'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
